// File: rtl/glitch_sequencer.sv
// Single-shot glitch sequencer: loads {delay, width, polarity} from the shift-in block, waits for
// a trigger edge, then drives glitch_out_o. Define GLITCH_SEQ_AUTO_REARM_EN to re-arm after DONE.
module glitch_sequencer #(
   parameter int unsigned CNT_WIDTH = 64,
   parameter int unsigned CFG_WIDTH = 2 * CNT_WIDTH + 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [CFG_WIDTH-1:0] cfg_data_i,
   input  logic                 cfg_ready_i,
   output logic                 shift_enable_o,
   input  logic                 arm_i,
   input  logic                 abort_i,
   input  logic                 trigger_i,
   output logic                 glitch_out_o,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [2:0]           state_dbg_o
);

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StLoad  = 3'd1,
      StArmed = 3'd2,
      StDelay = 3'd3,
      StPulse = 3'd4,
      StDone  = 3'd5
   } state_e;

   localparam logic [CNT_WIDTH-1:0] CntOne  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CntZero = '0;

   state_e               state_q;
   logic                 shift_en_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 glitch_q;
   logic                 pol_q;
   logic [CNT_WIDTH-1:0] delay_q;
   logic [CNT_WIDTH-1:0] width_q;
   logic [CNT_WIDTH-1:0] cnt_q;

   logic                 rdy_s1_q, rdy_s2_q;
   logic                 trig_s1_q, trig_s2_q, trig_s3_q;
   logic                 trig_rise;

   logic [CNT_WIDTH-1:0] cfg_delay;
   logic [CNT_WIDTH-1:0] cfg_width;
   logic                 cfg_pol;

   assign cfg_delay = cfg_data_i[CFG_WIDTH-1 -: CNT_WIDTH];
   assign cfg_width = cfg_data_i[CNT_WIDTH:1];
   assign cfg_pol   = cfg_data_i[0];

   // Two-flop synchronizers; the third trigger flop holds the previous synced level.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rdy_s1_q  <= 1'b0;
         rdy_s2_q  <= 1'b0;
         trig_s1_q <= 1'b0;
         trig_s2_q <= 1'b0;
         trig_s3_q <= 1'b0;
      end else begin
         rdy_s1_q  <= cfg_ready_i;
         rdy_s2_q  <= rdy_s1_q;
         trig_s1_q <= trigger_i;
         trig_s2_q <= trig_s1_q;
         trig_s3_q <= trig_s2_q;
      end
   end

   assign trig_rise = trig_s2_q & ~trig_s3_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         shift_en_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         glitch_q   <= 1'b0;
         pol_q      <= 1'b1;
         delay_q    <= CntZero;
         width_q    <= CntZero;
         cnt_q      <= CntZero;
      end else begin
         done_q <= 1'b0;
         if (state_q != StIdle && abort_i) begin
            state_q    <= StIdle;
            shift_en_q <= 1'b0;
            busy_q     <= 1'b0;
            glitch_q   <= ~pol_q;
         end else begin
            case (state_q)
               StIdle: begin
                  glitch_q <= ~pol_q;
                  if (arm_i && !abort_i) begin
                     state_q    <= StLoad;
                     shift_en_q <= 1'b1;
                     busy_q     <= 1'b1;
                  end
               end
               StLoad: begin
                  if (rdy_s2_q) begin
                     delay_q    <= cfg_delay;
                     width_q    <= cfg_width;
                     pol_q      <= cfg_pol;
                     glitch_q   <= ~cfg_pol;
                     shift_en_q <= 1'b0;
                     state_q    <= StArmed;
                  end
               end
               StArmed: begin
                  if (trig_rise) begin
                     if (delay_q != CntZero) begin
                        state_q <= StDelay;
                        cnt_q   <= delay_q;
                     end else if (width_q != CntZero) begin
                        state_q  <= StPulse;
                        cnt_q    <= width_q;
                        glitch_q <= pol_q;
                     end else begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                     end
                  end
               end
               StDelay: begin
                  if (cnt_q == CntOne) begin
                     if (width_q != CntZero) begin
                        state_q  <= StPulse;
                        cnt_q    <= width_q;
                        glitch_q <= pol_q;
                     end else begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                     end
                  end else begin
                     cnt_q <= cnt_q - CntOne;
                  end
               end
               StPulse: begin
                  if (cnt_q == CntOne) begin
                     state_q  <= StDone;
                     done_q   <= 1'b1;
                     glitch_q <= ~pol_q;
                  end else begin
                     cnt_q <= cnt_q - CntOne;
                  end
               end
               StDone: begin
`ifdef GLITCH_SEQ_AUTO_REARM_EN
                  state_q <= StArmed;
`else
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
`endif
               end
               default: begin
                  state_q    <= StIdle;
                  shift_en_q <= 1'b0;
                  busy_q     <= 1'b0;
                  glitch_q   <= ~pol_q;
               end
            endcase
         end
      end
   end

   assign shift_enable_o = shift_en_q;
   assign glitch_out_o   = glitch_q;
   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign state_dbg_o    = state_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Scoreboard bench for glitch_sequencer: per-cycle expectations are queued when stimulus is
// driven and compared at the falling edge of the cycle they describe.
module tb_glitch_sequencer;

`ifdef GLITCH_SEQ_AUTO_REARM_EN
   localparam bit Rearm = 1'b1;
`else
   localparam bit Rearm = 1'b0;
`endif

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StLoad  = 3'd1;
   localparam logic [2:0] StArmed = 3'd2;
   localparam logic [2:0] StDelay = 3'd3;
   localparam logic [2:0] StPulse = 3'd4;
   localparam logic [2:0] StDone  = 3'd5;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [128:0] cfg_data = '0;
   logic         cfg_ready = 1'b0;
   logic         shift_enable;
   logic         arm = 1'b0;
   logic         abort = 1'b0;
   logic         trigger = 1'b0;
   logic         glitch_out;
   logic         busy;
   logic         done;
   logic [2:0]   state_dbg;

   glitch_sequencer dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .cfg_data_i     (cfg_data),
      .cfg_ready_i    (cfg_ready),
      .shift_enable_o (shift_enable),
      .arm_i          (arm),
      .abort_i        (abort),
      .trigger_i      (trigger),
      .glitch_out_o   (glitch_out),
      .busy_o         (busy),
      .done_o         (done),
      .state_dbg_o    (state_dbg)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         c;
      logic [2:0] st;
      logic       se;
      logic       gl;
      logic       dn;
      logic       by;
      string      tag;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;
   logic m_pol = 1'b1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input int c, input logic [2:0] st, input logic se, input logic gl,
                       input logic dn, input logic by, input string tag);
      exp_t e;
      e.c = c; e.st = st; e.se = se; e.gl = gl; e.dn = dn; e.by = by; e.tag = tag;
      sb_q.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t  e;
      string t;
      while (sb_q.size() > 0 && sb_q[0].c <= cyc) begin
         e = sb_q.pop_front();
         t = $sformatf("%s@%0d", e.tag, e.c);
         if (e.c < cyc) begin
            check_eq({t, " stale"}, 64'(cyc), 64'(e.c));
         end else begin
            check_eq({t, " state"}, 64'(state_dbg), 64'(e.st));
            check_eq({t, " shift_en"}, 64'(shift_enable), 64'(e.se));
            check_eq({t, " glitch"}, 64'(glitch_out), 64'(e.gl));
            check_eq({t, " done"}, 64'(done), 64'(e.dn));
            check_eq({t, " busy"}, 64'(busy), 64'(e.by));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic drain();
      int n = 0;
      while (sb_q.size() != 0 && n < 2000) begin
         tick();
         n++;
      end
      if (sb_q.size() != 0) begin
         check_eq("drain", 64'(sb_q.size()), 64'd0);
         sb_q.delete();
      end
   endtask

   // Arm, emulate the shift-in block, raise ready off-clock and expect the 2-flop latency.
   task automatic load(input int unsigned d, input int unsigned w, input logic p, input string tag);
      int a, j;
      tick();
      a = cyc;
      arm = 1'b1;
      push(a + 1, StLoad, 1'b1, ~m_pol, 1'b0, 1'b1, {tag, " load"});
      tick();
      arm = 1'b0;
      cfg_data = {64'(d), 64'(w), p};
      repeat (4) tick();
      j = cyc;
      push(j + 1, StLoad, 1'b1, ~m_pol, 1'b0, 1'b1, {tag, " sync1"});
      push(j + 2, StLoad, 1'b1, ~m_pol, 1'b0, 1'b1, {tag, " sync2"});
      push(j + 3, StArmed, 1'b0, ~p, 1'b0, 1'b1, {tag, " latched"});
      #4 cfg_ready = 1'b1;
      repeat (3) tick();
      cfg_ready = 1'b0;
      m_pol = p;
      drain();
   endtask

   // Trigger edge in cycle k gives T = k + 2 after synchronization.
   task automatic fire(input int d, input int w, input bit extra, input int kill_off,
                       input bit kill_rst, input string tag);
      int   k, t, kill_at, end_c;
      logic p;
      p = m_pol;
      tick();
      k = cyc;
      t = k + 2;
      trigger = 1'b1;
      kill_at = (kill_off > 0) ? t + kill_off : 0;
      end_c = (kill_at != 0) ? kill_at + 3 : t + d + w + 2;
      for (int c = k + 1; c <= end_c; c++) begin
         if (c <= t)
            push(c, StArmed, 1'b0, ~p, 1'b0, 1'b1, tag);
         else if (kill_at != 0 && c > kill_at)
            push(c, StIdle, 1'b0, kill_rst ? 1'b0 : ~p, 1'b0, 1'b0, {tag, " killed"});
         else if (c <= t + d)
            push(c, StDelay, 1'b0, ~p, 1'b0, 1'b1, tag);
         else if (c <= t + d + w)
            push(c, StPulse, 1'b0, p, 1'b0, 1'b1, tag);
         else if (c == t + d + w + 1)
            push(c, StDone, 1'b0, ~p, 1'b1, 1'b1, tag);
         else
            push(c, Rearm ? StArmed : StIdle, 1'b0, ~p, 1'b0, Rearm, {tag, " after"});
      end
      while (cyc < end_c) begin
         tick();
         if (cyc == k + 3) trigger = 1'b0;
         if (extra && (cyc == k + 6 || cyc == k + 10)) trigger = 1'b1;
         if (extra && (cyc == k + 8 || cyc == k + 12)) trigger = 1'b0;
         if (kill_at != 0 && cyc == kill_at) begin
            if (kill_rst) rst = 1'b1;
            else abort = 1'b1;
         end
         if (kill_at != 0 && cyc == kill_at + 1) begin
            rst = 1'b0;
            abort = 1'b0;
         end
      end
      if (kill_at != 0 && kill_rst) m_pol = 1'b1;
      drain();
   endtask

   task automatic abort_now(input string tag);
      tick();
      abort = 1'b1;
      push(cyc + 1, StIdle, 1'b0, ~m_pol, 1'b0, 1'b0, tag);
      tick();
      abort = 1'b0;
      drain();
   endtask

   task automatic arm_blocked();
      int c;
      tick();
      c = cyc;
      arm = 1'b1;
      abort = 1'b1;
      push(c + 1, StIdle, 1'b0, ~m_pol, 1'b0, 1'b0, "arm_vs_abort");
      push(c + 2, StIdle, 1'b0, ~m_pol, 1'b0, 1'b0, "arm_vs_abort");
      tick();
      tick();
      arm = 1'b0;
      abort = 1'b0;
      drain();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      tick();
      tick();
      push(cyc + 1, StIdle, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
      tick();
      rst = 1'b0;
      drain();

      arm_blocked();

      load(5, 3, 1'b1, "basic");
      fire(5, 3, 1'b0, 0, 1'b0, "basic");
      abort_now("basic_idle");

      load(0, 1, 1'b0, "zero_delay");
      fire(0, 1, 1'b0, 0, 1'b0, "zero_delay");
      abort_now("zero_delay_idle");

      load(4, 0, 1'b1, "zero_width");
      fire(4, 0, 1'b0, 0, 1'b0, "zero_width");
      abort_now("zero_width_idle");

      load(0, 0, 1'b0, "zero_both");
      fire(0, 0, 1'b0, 0, 1'b0, "zero_both");
      abort_now("zero_both_idle");

      load(2, 100, 1'b1, "abort_pulse");
      fire(2, 100, 1'b0, 10, 1'b0, "abort_pulse");

      load(10, 12, 1'b1, "retrigger");
      fire(10, 12, 1'b1, 0, 1'b0, "retrigger");
      abort_now("retrigger_idle");

`ifdef GLITCH_SEQ_AUTO_REARM_EN
      load(2, 2, 1'b1, "rearm");
      for (int i = 0; i < 3; i++) begin
         fire(2, 2, 1'b0, 0, 1'b0, $sformatf("rearm%0d", i));
         repeat (40) tick();
      end
      abort_now("rearm_abort");
`endif

      load(3, 20, 1'b0, "rst_mid");
      fire(3, 20, 1'b0, 8, 1'b1, "rst_mid");

      load(1, 1, 1'b1, "recover");
      fire(1, 1, 1'b0, 0, 1'b0, "recover");
      abort_now("recover_idle");

      drain();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
